mips_mem_resp: RTL and testbench

MIPS_MEM_RESP -- requirements
Module: mips_mem_resp

---
 rtl/mips_mem_resp.sv | 149 ++++++++++++++
 tb/tb_mips_mem_resp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_resp.sv
// +------------------------------------------------------------------------+
// | mips_mem_resp                                                          |
// | Instruction/data memories for a small MIPS core, with a program-load   |
// | port into imem. Optional MMIO (cycle counter at 0xF8, io_out at 0xFC)  |
// | is enabled by defining MIPS_MEM_MMIO_EN.                               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module mips_mem_resp #(
  parameter int AW              = 6,
  parameter bit LOAD_EN_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_rst_n
`ifdef MIPS_MEM_MMIO_EN
  ,
  output logic [31:0] io_out
`endif
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int          c_depth     = 2 ** AW;
  localparam state_t      c_rst_state = LOAD_EN_DEFAULT ? LOAD : RUN;
  localparam logic [AW-1:0] c_last_ptr = '1;

  state_t          r_state;
  state_t          w_next_state;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   w_next_ptr;
  logic            r_core_rst_n;
  logic            w_load_fire;
  logic            w_store_fire;
  logic            w_dmem_we;
  logic [AW-1:0]   w_iaddr;
  logic [AW-1:0]   w_daddr;
  logic [31:0]     w_dmem_rd;
  logic            w_unused;

  logic [31:0]     r_imem [c_depth];
  logic [31:0]     r_dmem [c_depth];

  assign w_iaddr = pc[AW+1:2];
  assign w_daddr = aluout[AW+1:2];
  assign w_unused = ^{pc[31:AW+2], pc[1:0], aluout[31:AW+2], aluout[1:0]};

  // Load handshake and next-state logic; reset gates the strobes so nothing
  // is written while the block is held in reset.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_load_fire  = 1'b0;
    load_ready   = 1'b0;
    case (r_state)
      LOAD: begin
        load_ready = reset;
        if (load_valid && reset) begin
          w_load_fire = 1'b1;
          w_next_ptr  = r_ptr + AW'(1);
          if (load_last || (r_ptr == c_last_ptr)) begin
            w_next_state = RUN;
          end
        end
      end
      RUN: begin
        w_next_state = RUN;
      end
      default: begin
        w_next_state = c_rst_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_rst_state;
      r_ptr        <= '0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ptr        <= w_next_ptr;
      r_core_rst_n <= (r_state == RUN);
    end
  end

  assign core_rst_n   = r_core_rst_n;
  assign w_store_fire = memwrite && reset && (r_state == RUN);

  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_imem[r_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_dmem_we) begin
      r_dmem[w_daddr] <= writedata;
    end
  end

  assign instr     = (r_state == RUN) ? r_imem[w_iaddr] : 32'h0000_0000;
  assign w_dmem_rd = r_dmem[w_daddr];

`ifdef MIPS_MEM_MMIO_EN
  logic [31:0] r_cycle_cnt;
  logic        w_cnt_sel;
  logic        w_io_sel;

  assign w_cnt_sel = (aluout[7:0] == 8'hF8);
  assign w_io_sel  = (aluout[7:0] == 8'hFC);
  assign w_dmem_we = w_store_fire && !w_io_sel;
  assign readdata  = w_cnt_sel ? r_cycle_cnt : w_dmem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt <= 32'h0000_0000;
      io_out      <= 32'h0000_0000;
    end else begin
      if (r_state == RUN) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_store_fire && w_io_sel) begin
        io_out <= writedata;
      end
    end
  end
`else
  assign w_dmem_we = w_store_fire;
  assign readdata  = w_dmem_rd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_resp.sv
// Self-checking bench for mips_mem_resp: directed scenarios plus randomized
// load/run traffic checked every cycle against a word-level memory model.
`default_nettype none

module tb_mips_mem_resp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic [31:0] readdata;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_rst_n;
`ifdef MIPS_MEM_MMIO_EN
  logic [31:0] io_out;
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  mips_mem_resp #(.AW(6), .LOAD_EN_DEFAULT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .aluout     (aluout),
    .writedata  (writedata),
    .memwrite   (memwrite),
    .readdata   (readdata),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .core_rst_n (core_rst_n)
`ifdef MIPS_MEM_MMIO_EN
    ,
    .io_out     (io_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Word-level model: memories with written-flags, a loading flag and a
  // load pointer, plus the delayed core reset and optional MMIO registers.
  logic [31:0] mi [DEPTH];
  logic [31:0] md [DEPTH];
  bit          miv [DEPTH];
  bit          mdv [DEPTH];
  bit          m_loading;
  int          m_ptr;
  bit          m_crst;
  logic [31:0] m_cnt;
  logic [31:0] m_io;
  int          ptr_log[$];

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_loading <= 1'b1;
      m_ptr     <= 0;
      m_crst    <= 1'b0;
      m_cnt     <= '0;
      m_io      <= '0;
    end else begin
      m_crst <= !m_loading;
      if (!m_loading) m_cnt <= m_cnt + 1;
      if (m_loading) begin
        if (load_valid) begin
          mi[m_ptr]  <= load_data;
          miv[m_ptr] <= 1'b1;
          ptr_log.push_back(m_ptr);
          m_ptr <= m_ptr + 1;
          if (load_last || m_ptr == DEPTH - 1) m_loading <= 1'b0;
        end
      end else if (memwrite) begin
        if (MMIO && aluout[7:0] == 8'hFC) begin
          m_io <= writedata;
        end else begin
          md[word_of(aluout)]  <= writedata;
          mdv[word_of(aluout)] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
      chk("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    end else begin
      chk("load_ready", {31'b0, load_ready}, {31'b0, m_loading});
      chk("core_rst_n", {31'b0, core_rst_n}, {31'b0, m_crst});
      if (m_loading) chk("instr_nop", instr, 32'h0);
      else if (miv[word_of(pc)]) chk("instr", instr, mi[word_of(pc)]);
      if (MMIO && aluout[7:0] == 8'hF8) chk("readdata_cnt", readdata, m_cnt);
      else if (mdv[word_of(aluout)]) chk("readdata", readdata, md[word_of(aluout)]);
`ifdef MIPS_MEM_MMIO_EN
      chk("io_out", io_out, m_io);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; memwrite = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bit pat [5] = '{1, 0, 1, 0, 1};

    // Program load of three words
    do_reset();
    chk("load_ready_after_release", {31'b0, load_ready}, 32'd1);
    load_word(32'h2001_0008, 1'b0);
    load_word(32'h2003_0010, 1'b0);
    load_word(32'h0000_0000, 1'b1);
    chk("load_ready_after_last", {31'b0, load_ready}, 32'd0);
    chk("core_rst_n_same_cycle", {31'b0, core_rst_n}, 32'd0);
    step();
    chk("core_rst_n_one_later", {31'b0, core_rst_n}, 32'd1);
    pc = 32'd4; #1;
    chk("instr_pc4", instr, 32'h2003_0010);

    // Full-depth load without load_last
    do_reset();
    ptr_log.delete();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(32'hA500_0000 + i, 1'b0);
      if (i == DEPTH - 2) chk("full_ready_before_last", {31'b0, load_ready}, 32'd1);
    end
    chk("full_ready_after_last", {31'b0, load_ready}, 32'd0);
    chk("full_ptr_count", ptr_log.size(), DEPTH);
    step();
    pc = 32'hFC; #1;
    chk("full_instr_fc", instr, 32'hA500_003F);

    // Backpressure gaps: valid 1,0,1,0,1, last on third accepted word
    do_reset();
    ptr_log.delete();
    for (int k = 0; k < 5; k++) begin
      load_valid = pat[k]; load_data = 32'hB000_0000 + k; load_last = (k == 4);
      step();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("gap_words", ptr_log.size(), 3);
    for (int k = 0; k < 3 && k < ptr_log.size(); k++) chk("gap_ptr", ptr_log[k], k);
    step();
    pc = 32'd0; #1; chk("gap_instr0", instr, 32'hB000_0000);
    pc = 32'd8; #1; chk("gap_instr2", instr, 32'hB000_0004);
    pc = 32'd12; #1; chk("gap_instr3_untouched", instr, 32'hA500_0003);

    // Reset mid-load, then reload a single word
    do_reset();
    load_word(32'hC000_0000, 1'b0);
    load_word(32'hC000_0001, 1'b0);
    reset = 1'b0; #1;
    chk("midload_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    step();
    reset = 1'b1; #1;
    chk("midload_ready_again", {31'b0, load_ready}, 32'd1);
    load_word(32'hD000_0000, 1'b1);
    chk("reload_core_rst_n_low", {31'b0, core_rst_n}, 32'd0);
    step();
    chk("reload_core_rst_n_high", {31'b0, core_rst_n}, 32'd1);
    pc = 32'd0; #1; chk("reload_imem0", instr, 32'hD000_0000);
    pc = 32'd4; #1; chk("reload_imem1_old", instr, 32'hC000_0001);

    // Store then load, same word old/new data
    aluout = 32'd4; writedata = 32'd7; memwrite = 1'b1;
    step();
    aluout = 32'd6; writedata = 32'd35; #1;
    chk("store_cycle_old", readdata, 32'd7);
    step();
    memwrite = 1'b0; aluout = 32'd4; #1;
    chk("store_next_new", readdata, 32'd35);

`ifdef MIPS_MEM_MMIO_EN
    aluout = 32'hFD; writedata = 32'h1234; memwrite = 1'b1;
    step();
    aluout = 32'hFC; writedata = 32'h5A;
    step();
    memwrite = 1'b0; #1;
    chk("mmio_io_out", io_out, 32'h5A);
    chk("mmio_dmem63_kept", readdata, 32'h1234);
    aluout = 32'hF8; #1;
    a = readdata;
    step();
    b = readdata;
    chk("mmio_cnt_delta", b - a, 32'd1);
`else
    a = 32'd0; b = 32'd0;
`endif

    // Randomized load with gaps, then random run traffic
    for (int r = 0; r < 3; r++) begin
      int n, got;
      do_reset();
      n = $urandom_range(1, 20);
      got = 0;
      while (got < n) begin
        load_valid = ($urandom_range(0, 2) != 0);
        load_data  = $urandom;
        load_last  = (got == n - 1);
        if (load_valid) got++;
        step();
      end
      load_valid = 1'b0; load_last = 1'b0;
      for (int c = 0; c < 150; c++) begin
        pc        = {$urandom_range(0, 3), 2'b00} << 2 | ($urandom & 32'hFFFF_FF00) | 32'(($urandom_range(0, 15)) << 2);
        aluout    = ($urandom_range(0, 3) == 0) ? $urandom : 32'(($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        writedata = $urandom;
        memwrite  = ($urandom_range(0, 1) == 1);
        load_valid = ($urandom_range(0, 3) == 0);
        load_data  = $urandom;
        step();
      end
      memwrite = 1'b0; load_valid = 1'b0;
    end

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
